multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Port clk: input, 1 bit; the system clock; all state changes on its rising edge.
REQ-002 Port resetn: input, 1 bit; reset, synchronous, active-low.
REQ-003 Port ir: input, 32 bits; the latched instruction register.
REQ-004 Port rs_eq_rt: input, 1 bit; the datapath comparison GPR[rs]==GPR[rt].
REQ-005 Port div_done: input, 1 bit; a one-cycle completion pulse from the iterative divider.
REQ-006 Port ir_wen: output, 1 bit; latches the instruction ROM output into the IR.
REQ-007 Port pc_wen: output, 1 bit; loads the PC.
REQ-008 Port pc_src: output, 2 bits; PC source select: 00 seq_pc, 01 branch target, 10 jump target.
REQ-009 Port rf_wen: output, 1 bit; GPR write enable.
REQ-010 Port rf_wdest_rd: output, 1 bit; selects the write address, 1 = rd, 0 = rt.
REQ-011 Port rf_wsrc_mem: output, 1 bit; selects the write data, 1 = dm_rdata, 0 = ALU result.
REQ-012 Port hilo_wen: output, 1 bit; HI/LO write enable.
REQ-013 Port dm_wen: output, 4 bits; data RAM byte write enables.
REQ-014 Port div_start: output, 1 bit; a one-cycle divider launch pulse.
REQ-015 Port alu_control: output, 14 bits; one-hot, bit 13 to bit 0 = {div, mul, add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
REQ-016 Port alu_src1_sa: output, 1 bit; selects operand 1 = zero-extended sa.
REQ-017 Port alu_src2_imm: output, 1 bit; selects operand 2 = sign-extended immediate.
REQ-018 Port state: output, 3 bits; the current FSM state, for display.
REQ-019 Port retire: output, 1 bit; a one-cycle pulse in each instruction's final cycle.

Function
REQ-020 The FSM SHALL use the state encodings IF=0, ID=1, EX=2, DIVW=3, MEM=4, WB=5; codes 6 and 7 SHALL go to IF on the next edge with all enables 0.
REQ-021 The block SHALL decode these classes from ir: ADDU, SUBU, SLT, AND, NOR, OR, XOR, SLL, SRL, MUL, DIV, ADDIU, LUI, LW, SW, BEQ, BNE, J, using standard MIPS op/funct values; SLL and SRL SHALL also require rs=0, and R-type ALU ops SHALL also require sa=0.
REQ-022 IF SHALL assert ir_wen=1 and then go to ID.
REQ-023 ID with J SHALL assert pc_wen=1, pc_src=10 and retire, then go to IF.
REQ-024 ID with BEQ SHALL assert pc_wen=1, pc_src=01 if rs_eq_rt else 00, and retire, then go to IF.
REQ-025 ID with BNE SHALL behave as BEQ with the rs_eq_rt test inverted.
REQ-026 ID with an undecoded instruction SHALL treat it as a NOP: pc_wen=1, pc_src=00, retire, then go to IF.
REQ-027 ID with any other decoded instruction SHALL go to EX.
REQ-028 EX SHALL drive alu_control, alu_src1_sa and alu_src2_imm; for DIV it SHALL pulse div_start for exactly one cycle and go to DIVW; for LW/SW it SHALL go to MEM; otherwise it SHALL go to WB.
REQ-029 DIVW SHALL hold alu_control with div_start=0 and go to WB on the cycle div_done=1 is sampled; there SHALL be no timeout.
REQ-030 MEM with SW SHALL assert dm_wen=4'hF, pc_wen=1, pc_src=00 and retire, then go to IF.
REQ-031 MEM with LW SHALL go to WB.
REQ-032 WB SHALL assert pc_wen=1, pc_src=00 and retire, then go to IF.
REQ-033 WB with DIV SHALL assert hilo_wen=1 and rf_wen=0.
REQ-034 WB otherwise SHALL assert rf_wen=1, with rf_wdest_rd=1 for R-type/MUL, rf_wdest_rd=0 for ADDIU/LUI/LW, and rf_wsrc_mem=1 only for LW.
REQ-035 alu_control SHALL be 0 in IF and ID; in EX, MEM and WB it SHALL follow the decoded ir (add for ADDU/ADDIU/LW/SW).
REQ-036 alu_src2_imm SHALL be 1 for ADDIU/LUI/LW/SW; alu_src1_sa SHALL be 1 for SLL/SRL.
REQ-037 Instruction latency in cycles SHALL be: J/BEQ/BNE/NOP 2, ALU 4, SW 4, LW 5, DIV 4+N where N is the number of DIVW cycles (at least 1).
REQ-038 div_done sampled in any state other than DIVW SHALL be ignored.
REQ-039 Every write enable (ir_wen, pc_wen, rf_wen, hilo_wen, dm_wen) and div_start SHALL be pulses of at most one cycle per instruction.

Reset
REQ-040 While resetn=0, all enables, div_start, retire and alu_control SHALL be forced to 0 combinationally in the same cycle, and state SHALL load IF on the edge.
REQ-041 Reset asserted mid-operation, including during DIVW, SHALL abandon the instruction with no writes; after release the first cycle SHALL be IF.

Structure
REQ-042 Package cpu_defs SHALL hold the opcode/funct constants, the state encodings and the alu_control bit indices.
REQ-043 Combinational decode SHALL be a sub-module inst_decode producing the one-hot inst_* classes; the FSM and output logic SHALL live in multi_cycle_ctrl.

Verification
REQ-044 Scenario: ir=ADDU $3,$1,$2 (0x00221821) -> state sequence 0,1,2,5; rf_wen=1 and rf_wdest_rd=1 in WB only; alu_control=0x0800 in EX; retire once.
REQ-045 Scenario: ir=LW $4,8($0) (0x8C040008) -> states 0,1,2,4,5; rf_wsrc_mem=1 and rf_wen=1 in WB; alu_src2_imm=1 in EX; no dm_wen.
REQ-046 Scenario: ir=SW (0xAC040008) -> dm_wen=4'hF for exactly one cycle in MEM; no rf_wen; 4 cycles total.
REQ-047 Scenario: ir=BEQ (0x10220003) with rs_eq_rt=1, then rs_eq_rt=0 -> pc_src=01, then 00, in ID; 2 cycles each.
REQ-048 Scenario: ir=DIV (0x0022001A), div_done after 5 DIVW cycles -> div_start is a single pulse; hilo_wen=1 in WB; a stray div_done in EX is ignored; 9 cycles total.
REQ-049 Scenario: resetn=0 during DIVW -> all enables 0 that cycle; IF on the next edge; no hilo_wen ever asserted.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared definitions for the multi-cycle MIPS control slice:
//     - opcode / funct field values of the supported instructions
//     - FSM state encodings (plain 3-bit constants, kept legacy-compatible)
//     - bit positions inside the one-hot alu_control bus
//     - inst_class_t, the one-hot instruction class vector from inst_decode
// ---------------------------------------------------------------------------
package cpu_defs;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // SPECIAL / SPECIAL2 function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

    // FSM state encodings
    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_DIVW = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;

    // alu_control bit indices
    localparam int ALU_DIV  = 13;
    localparam int ALU_MUL  = 12;
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    // At most one field is set; all zero means "not a supported instruction".
    typedef struct packed {
        logic inst_addu;
        logic inst_subu;
        logic inst_slt;
        logic inst_and;
        logic inst_nor;
        logic inst_or;
        logic inst_xor;
        logic inst_sll;
        logic inst_srl;
        logic inst_mul;
        logic inst_div;
        logic inst_addiu;
        logic inst_lui;
        logic inst_lw;
        logic inst_sw;
        logic inst_beq;
        logic inst_bne;
        logic inst_j;
    } inst_class_t;

endpackage

// File: rtl/multi_cycle_ctrl_inst_decode.sv
// ---------------------------------------------------------------------------
// inst_decode
//   Purely combinational classification of a 32-bit MIPS instruction into
//   the one-hot inst_* classes understood by the multi-cycle controller.
//   Ports:
//     ir   - instruction register contents
//     cls  - one-hot instruction class (all zero for unsupported encodings)
// ---------------------------------------------------------------------------
module inst_decode
    import cpu_defs::*;
(
    input  logic [31:0]  ir,
    output inst_class_t  cls
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] sa;
    logic [5:0] fn;
    logic       rtype;
    logic       sa_zero;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign sa      = ir[10:6];
    assign fn      = ir[5:0];
    assign rtype   = (op == OP_SPECIAL);
    assign sa_zero = (sa == 5'd0);

    // rt and rd only steer the datapath, never the control flow
    wire unused_reg_fields = ^ir[20:11];

    // Register-register ALU ops insist on a zero shift field; the shifts
    // instead insist on rs being zero, as in the architectural encoding.
    always_comb begin
        cls            = '0;
        cls.inst_addu  = rtype && fn == FN_ADDU && sa_zero;
        cls.inst_subu  = rtype && fn == FN_SUBU && sa_zero;
        cls.inst_slt   = rtype && fn == FN_SLT  && sa_zero;
        cls.inst_and   = rtype && fn == FN_AND  && sa_zero;
        cls.inst_nor   = rtype && fn == FN_NOR  && sa_zero;
        cls.inst_or    = rtype && fn == FN_OR   && sa_zero;
        cls.inst_xor   = rtype && fn == FN_XOR  && sa_zero;
        cls.inst_sll   = rtype && fn == FN_SLL  && rs == 5'd0;
        cls.inst_srl   = rtype && fn == FN_SRL  && rs == 5'd0;
        cls.inst_div   = rtype && fn == FN_DIV;
        cls.inst_mul   = (op == OP_SPECIAL2) && fn == FN_MUL;
        cls.inst_addiu = (op == OP_ADDIU);
        cls.inst_lui   = (op == OP_LUI);
        cls.inst_lw    = (op == OP_LW);
        cls.inst_sw    = (op == OP_SW);
        cls.inst_beq   = (op == OP_BEQ);
        cls.inst_bne   = (op == OP_BNE);
        cls.inst_j     = (op == OP_J);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   FSM controller for a multi-cycle MIPS subset
//   (IF -> ID -> EX -> [DIVW | MEM] -> WB).
//   Ports:
//     clk, resetn      - clock, synchronous active-low reset
//     ir               - latched instruction
//     rs_eq_rt         - GPR[rs] == GPR[rt] from the datapath
//     div_done         - divider completion pulse (only heeded in DIVW)
//     ir_wen, pc_wen   - IR / PC load enables
//     pc_src           - 00 seq, 01 branch target, 10 jump target
//     rf_wen, rf_wdest_rd, rf_wsrc_mem - GPR write enable / address / data select
//     hilo_wen, dm_wen - HI/LO and data RAM byte write enables
//     div_start        - one-cycle divider launch
//     alu_control      - one-hot ALU operation
//     alu_src1_sa, alu_src2_imm - ALU operand selects
//     state            - current FSM state
//     retire           - pulse in each instruction's last cycle
// ---------------------------------------------------------------------------
module multi_cycle_ctrl
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] ir,
    input  logic        rs_eq_rt,
    input  logic        div_done,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic [1:0]  pc_src,
    output logic        rf_wen,
    output logic        rf_wdest_rd,
    output logic        rf_wsrc_mem,
    output logic        hilo_wen,
    output logic [3:0]  dm_wen,
    output logic        div_start,
    output logic [13:0] alu_control,
    output logic        alu_src1_sa,
    output logic        alu_src2_imm,
    output logic [2:0]  state,
    output logic        retire
);

    inst_class_t cls;
    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic        valid;
    logic        ctrl_flow;
    logic [13:0] alu_dec;
    logic        alu_active;

    inst_decode u_decode (
        .ir  (ir),
        .cls (cls)
    );

    assign valid     = |cls;
    assign ctrl_flow = cls.inst_j | cls.inst_beq | cls.inst_bne;
    assign state     = state_q;

    // Operation requested by the current instruction; memory ops reuse add
    // for address generation.
    always_comb begin
        alu_dec           = '0;
        alu_dec[ALU_DIV]  = cls.inst_div;
        alu_dec[ALU_MUL]  = cls.inst_mul;
        alu_dec[ALU_ADD]  = cls.inst_addu | cls.inst_addiu | cls.inst_lw | cls.inst_sw;
        alu_dec[ALU_SUB]  = cls.inst_subu;
        alu_dec[ALU_SLT]  = cls.inst_slt;
        alu_dec[ALU_AND]  = cls.inst_and;
        alu_dec[ALU_NOR]  = cls.inst_nor;
        alu_dec[ALU_OR]   = cls.inst_or;
        alu_dec[ALU_XOR]  = cls.inst_xor;
        alu_dec[ALU_SLL]  = cls.inst_sll;
        alu_dec[ALU_SRL]  = cls.inst_srl;
        alu_dec[ALU_LUI]  = cls.inst_lui;
    end

    // State register; reset is synchronous so the abandoned instruction
    // simply never reaches its write cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Unused codes fall back to IF.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:   state_d = S_ID;
            S_ID:   state_d = (ctrl_flow || !valid) ? S_IF : S_EX;
            S_EX: begin
                if (cls.inst_div) begin
                    state_d = S_DIVW;
                end else if (cls.inst_lw || cls.inst_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_DIVW: state_d = div_done ? S_WB : S_DIVW;
            S_MEM:  state_d = cls.inst_sw ? S_IF : S_WB;
            S_WB:   state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // ALU selects stay valid from EX through WB so the datapath result is
    // stable while it is being written back.
    assign alu_active = (state_q == S_EX) || (state_q == S_DIVW) ||
                        (state_q == S_MEM) || (state_q == S_WB);

    // Moore-style outputs, except the branch PC select which looks at
    // rs_eq_rt directly in ID. Reset masks everything in the same cycle.
    always_comb begin
        ir_wen       = 1'b0;
        pc_wen       = 1'b0;
        pc_src       = 2'b00;
        rf_wen       = 1'b0;
        rf_wdest_rd  = 1'b0;
        rf_wsrc_mem  = 1'b0;
        hilo_wen     = 1'b0;
        dm_wen       = 4'h0;
        div_start    = 1'b0;
        retire       = 1'b0;
        alu_control  = alu_active ? alu_dec : 14'd0;
        alu_src1_sa  = alu_active && (cls.inst_sll || cls.inst_srl);
        alu_src2_imm = alu_active && (cls.inst_addiu || cls.inst_lui ||
                                      cls.inst_lw || cls.inst_sw);
        case (state_q)
            S_IF: ir_wen = 1'b1;
            S_ID: begin
                if (cls.inst_j) begin
                    pc_wen = 1'b1;
                    pc_src = 2'b10;
                    retire = 1'b1;
                end else if (cls.inst_beq || cls.inst_bne) begin
                    pc_wen = 1'b1;
                    pc_src = ((rs_eq_rt ^ cls.inst_bne) != 1'b0) ? 2'b01 : 2'b00;
                    retire = 1'b1;
                end else if (!valid) begin
                    pc_wen = 1'b1;
                    retire = 1'b1;
                end
            end
            S_EX: div_start = cls.inst_div;
            S_MEM: begin
                if (cls.inst_sw) begin
                    dm_wen = 4'hF;
                    pc_wen = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                pc_wen = 1'b1;
                retire = 1'b1;
                if (cls.inst_div) begin
                    hilo_wen = 1'b1;
                end else begin
                    rf_wen      = 1'b1;
                    rf_wdest_rd = !(cls.inst_addiu || cls.inst_lui || cls.inst_lw);
                    rf_wsrc_mem = cls.inst_lw;
                end
            end
            default: ;
        endcase
        if (!resetn) begin
            ir_wen       = 1'b0;
            pc_wen       = 1'b0;
            pc_src       = 2'b00;
            rf_wen       = 1'b0;
            rf_wdest_rd  = 1'b0;
            rf_wsrc_mem  = 1'b0;
            hilo_wen     = 1'b0;
            dm_wen       = 4'h0;
            div_start    = 1'b0;
            retire       = 1'b0;
            alu_control  = 14'd0;
            alu_src1_sa  = 1'b0;
            alu_src2_imm = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed bench for multi_cycle_ctrl: each instruction is run from IF to
//   its retire cycle, every cycle's outputs are recorded, and the recorded
//   trace is compared with hand-derived values.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        resetn;
    logic [31:0] ir;
    logic        rs_eq_rt;
    logic        div_done;
    logic        ir_wen;
    logic        pc_wen;
    logic [1:0]  pc_src;
    logic        rf_wen;
    logic        rf_wdest_rd;
    logic        rf_wsrc_mem;
    logic        hilo_wen;
    logic [3:0]  dm_wen;
    logic        div_start;
    logic [13:0] alu_control;
    logic        alu_src1_sa;
    logic        alu_src2_imm;
    logic [2:0]  state;
    logic        retire;

    int testCount = 0;
    int failCount = 0;

    // Per-cycle trace of the most recent instruction
    int          nCyc;
    logic [63:0] seq;
    logic [2:0]  tState [32];
    logic        tIrWen [32];
    logic        tPcWen [32];
    logic [1:0]  tPcSrc [32];
    logic        tRfWen [32];
    logic        tWdest [32];
    logic        tWsrc  [32];
    logic        tHilo  [32];
    logic [3:0]  tDm    [32];
    logic        tDivSt [32];
    logic [13:0] tAlu   [32];
    logic        tSrc1  [32];
    logic        tSrc2  [32];
    int          rfCnt;
    int          dmCnt;
    int          divStCnt;
    int          hiloCnt;

    multi_cycle_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ir           (ir),
        .rs_eq_rt     (rs_eq_rt),
        .div_done     (div_done),
        .ir_wen       (ir_wen),
        .pc_wen       (pc_wen),
        .pc_src       (pc_src),
        .rf_wen       (rf_wen),
        .rf_wdest_rd  (rf_wdest_rd),
        .rf_wsrc_mem  (rf_wsrc_mem),
        .hilo_wen     (hilo_wen),
        .dm_wen       (dm_wen),
        .div_start    (div_start),
        .alu_control  (alu_control),
        .alu_src1_sa  (alu_src1_sa),
        .alu_src2_imm (alu_src2_imm),
        .state        (state),
        .retire       (retire)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report it when it disagrees
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Runs one instruction starting in the IF cycle (called just after a
    // falling edge). div_done is raised in cycles doneK and strayK.
    task automatic applyStimulus(input logic [31:0] instr, input logic eq,
                                 input int doneK, input int strayK);
        bit finished;
        finished = 1'b0;
        ir       = instr;
        rs_eq_rt = eq;
        nCyc     = 0;
        seq      = '0;
        rfCnt    = 0;
        dmCnt    = 0;
        divStCnt = 0;
        hiloCnt  = 0;
        for (int k = 0; k < 30 && !finished; k++) begin
            div_done = (k == doneK) || (k == strayK);
            #1;
            tState[k] = state;
            tIrWen[k] = ir_wen;
            tPcWen[k] = pc_wen;
            tPcSrc[k] = pc_src;
            tRfWen[k] = rf_wen;
            tWdest[k] = rf_wdest_rd;
            tWsrc[k]  = rf_wsrc_mem;
            tHilo[k]  = hilo_wen;
            tDm[k]    = dm_wen;
            tDivSt[k] = div_start;
            tAlu[k]   = alu_control;
            tSrc1[k]  = alu_src1_sa;
            tSrc2[k]  = alu_src2_imm;
            seq       = (seq << 4) | 64'(state);
            rfCnt    += int'(rf_wen);
            dmCnt    += int'(dm_wen != 4'h0);
            divStCnt += int'(div_start);
            hiloCnt  += int'(hilo_wen);
            nCyc      = k + 1;
            finished  = retire;
            @(negedge clk);
        end
        div_done = 1'b0;
        if (!finished) begin
            checkOutput("retire_timeout", 64'(nCyc), 64'd0);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        ir       = 32'h00221821;
        rs_eq_rt = 1'b0;
        div_done = 1'b0;

        // Reset: outputs masked in the same cycle, IF after the edge
        @(negedge clk);
        #1;
        checkOutput("rst_enables", {ir_wen, pc_wen, rf_wen, hilo_wen, dm_wen,
                                    div_start, retire, alu_control}, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_state", 64'(state), 64'd0);
        resetn = 1'b1;
        #1;
        checkOutput("rst_release_irwen", 64'(ir_wen), 64'd1);

        // ADDU $3,$1,$2
        applyStimulus(32'h00221821, 1'b0, 99, 99);
        checkOutput("addu_seq", seq, 64'h0125);
        checkOutput("addu_irwen_if", 64'(tIrWen[0]), 64'd1);
        checkOutput("addu_alu_ex", 64'(tAlu[2]), 64'h0800);
        checkOutput("addu_rfwen_cnt", 64'(rfCnt), 64'd1);
        checkOutput("addu_wb_rf", {62'd0, tRfWen[3], tWdest[3]}, 64'h3);
        checkOutput("addu_wb_pc", {61'd0, tPcWen[3], tPcSrc[3]}, 64'h4);

        // LW $4,8($0)
        applyStimulus(32'h8C040008, 1'b0, 99, 99);
        checkOutput("lw_seq", seq, 64'h01245);
        checkOutput("lw_src2_ex", 64'(tSrc2[2]), 64'd1);
        checkOutput("lw_wb", {61'd0, tRfWen[4], tWsrc[4], tWdest[4]}, 64'h6);
        checkOutput("lw_dm_cnt", 64'(dmCnt), 64'd0);

        // SW
        applyStimulus(32'hAC040008, 1'b0, 99, 99);
        checkOutput("sw_seq", seq, 64'h0124);
        checkOutput("sw_dm_mem", 64'(tDm[3]), 64'hF);
        checkOutput("sw_dm_cnt", 64'(dmCnt), 64'd1);
        checkOutput("sw_rf_cnt", 64'(rfCnt), 64'd0);

        // BEQ taken / not taken
        applyStimulus(32'h10220003, 1'b1, 99, 99);
        checkOutput("beq_t_cyc", 64'(nCyc), 64'd2);
        checkOutput("beq_t_pc", {61'd0, tPcWen[1], tPcSrc[1]}, 64'h5);
        applyStimulus(32'h10220003, 1'b0, 99, 99);
        checkOutput("beq_nt_cyc", 64'(nCyc), 64'd2);
        checkOutput("beq_nt_pc", {61'd0, tPcWen[1], tPcSrc[1]}, 64'h4);

        // BNE with equal operands is not taken
        applyStimulus(32'h14220003, 1'b1, 99, 99);
        checkOutput("bne_pc", {61'd0, tPcWen[1], tPcSrc[1]}, 64'h4);

        // J
        applyStimulus(32'h08000010, 1'b0, 99, 99);
        checkOutput("j_cyc", 64'(nCyc), 64'd2);
        checkOutput("j_pcsrc", 64'(tPcSrc[1]), 64'h2);

        // Undecoded opcode and ADDU with non-zero sa both act as NOP
        applyStimulus(32'hFC000000, 1'b0, 99, 99);
        checkOutput("nop_cyc", 64'(nCyc), 64'd2);
        checkOutput("nop_pc", {61'd0, tPcWen[1], tPcSrc[1]}, 64'h4);
        applyStimulus(32'h00221861, 1'b0, 99, 99);
        checkOutput("addu_sa_nop_cyc", 64'(nCyc), 64'd2);

        // SLL $2,$2,2
        applyStimulus(32'h00021080, 1'b0, 99, 99);
        checkOutput("sll_alu", 64'(tAlu[2]), 64'h0008);
        checkOutput("sll_src1", 64'(tSrc1[2]), 64'd1);

        // LUI $1,0x1234 writes rt
        applyStimulus(32'h3C011234, 1'b0, 99, 99);
        checkOutput("lui_alu", 64'(tAlu[2]), 64'h0001);
        checkOutput("lui_wb", {61'd0, tRfWen[3], tWdest[3], tSrc2[2]}, 64'h5);

        // MUL $3,$1,$2 writes rd
        applyStimulus(32'h70221802, 1'b0, 99, 99);
        checkOutput("mul_seq", seq, 64'h0125);
        checkOutput("mul_alu", 64'(tAlu[2]), 64'h1000);
        checkOutput("mul_wdest", 64'(tWdest[3]), 64'd1);

        // DIV: stray div_done in EX, real one in the 5th DIVW cycle
        applyStimulus(32'h0022001A, 1'b0, 7, 2);
        checkOutput("div_seq", seq, 64'h012333335);
        checkOutput("div_cyc", 64'(nCyc), 64'd9);
        checkOutput("div_start_cnt", 64'(divStCnt), 64'd1);
        checkOutput("div_start_ex", 64'(tDivSt[2]), 64'd1);
        checkOutput("div_alu_divw", 64'(tAlu[5]), 64'h2000);
        checkOutput("div_wb", {62'd0, tHilo[8], tRfWen[8]}, 64'h2);

        // Reset during DIVW abandons the divide
        ir       = 32'h0022001A;
        div_done = 1'b0;
        hiloCnt  = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            hiloCnt += int'(hilo_wen);
            @(negedge clk);
        end
        #1;
        checkOutput("rstdiv_in_divw", 64'(state), 64'd3);
        resetn = 1'b0;
        #1;
        checkOutput("rstdiv_enables", {ir_wen, pc_wen, rf_wen, hilo_wen, dm_wen,
                                       div_start, retire, alu_control}, 64'd0);
        hiloCnt += int'(hilo_wen);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checkOutput("rstdiv_state_if", 64'(state), 64'd0);
        checkOutput("rstdiv_hilo_cnt", 64'(hiloCnt), 64'd0);

        // Machine resumes cleanly from IF
        applyStimulus(32'h00221821, 1'b0, 99, 99);
        checkOutput("post_rst_seq", seq, 64'h0125);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
